// File: rtl/legv8_pkg.sv
`default_nettype none
// ============================================================================
// Module      : legv8_pkg
// Description : Shared definitions for the LEGv8 control unit and datapath:
//               sequencer states, opcode prefixes, ALU function codes and
//               control-word bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package legv8_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    RESET_S = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    EXECUTE = 3'd3,
    HALT    = 3'd4
  } state_t;

  // Branch behaviour resolved in EXECUTE
  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_B    = 2'd1,
    BR_CBZ  = 2'd2,
    BR_CBNZ = 2'd3
  } br_kind_t;

  // Opcode prefixes, grouped by how many leading bits identify them
  localparam logic [10:0] C_OP_ADD  = 11'b10001011000;
  localparam logic [10:0] C_OP_SUB  = 11'b11001011000;
  localparam logic [10:0] C_OP_AND  = 11'b10001010000;
  localparam logic [10:0] C_OP_ORR  = 11'b10101010000;
  localparam logic [10:0] C_OP_LDUR = 11'b11111000010;
  localparam logic [10:0] C_OP_STUR = 11'b11111000000;
  localparam logic [9:0]  C_OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  C_OP_SUBI = 10'b1101000100;
  localparam logic [7:0]  C_OP_CBZ  = 8'b10110100;
  localparam logic [7:0]  C_OP_CBNZ = 8'b10110101;
  localparam logic [5:0]  C_OP_B    = 6'b000101;

  // ALU function select codes
  localparam logic [4:0] C_FS_ADD = 5'b01000;
  localparam logic [4:0] C_FS_SUB = 5'b01001;
  localparam logic [4:0] C_FS_AND = 5'b00000;
  localparam logic [4:0] C_FS_OR  = 5'b00100;

  // Memory access sizes
  localparam logic [1:0] C_SIZE_WORD  = 2'b10;
  localparam logic [1:0] C_SIZE_DWORD = 2'b11;

  // Control-word bit positions (fields are 5 bits wide unless noted)
  localparam int C_CW_SB_LSB   = 0;
  localparam int C_CW_SA_LSB   = 5;
  localparam int C_CW_DA_LSB   = 10;
  localparam int C_CW_RW       = 15;
  localparam int C_CW_MW       = 16;
  localparam int C_CW_SIZE_LSB = 17;  // 2 bits
  localparam int C_CW_C0       = 19;
  localparam int C_CW_FS_LSB   = 20;
  localparam int C_CW_SL       = 25;
  localparam int C_CW_IL       = 26;
  localparam int C_CW_BSEL     = 27;
  localparam int C_CW_CS       = 28;
  localparam int C_CW_WE       = 29;
  localparam int C_CW_RE       = 30;
  localparam int C_CW_ADDR_SEL = 31;

endpackage
`default_nettype wire

// File: rtl/legv8_decoder.sv
`default_nettype none
// ============================================================================
// Module      : legv8_decoder
// Description : Combinational decode of a LEGv8 instruction into the EXECUTE
//               control word, immediate constant, branch kind and offset.
// Revision    : 1.0 - initial release
// ============================================================================
module legv8_decoder
  import legv8_pkg::*;
(
  input  logic [31:0] i_instr,
  output logic [31:0] o_cw,
  output logic [63:0] o_constant,
  output logic [1:0]  o_br_kind,
  output logic [31:0] o_br_offset,  // byte offset, already sign-extended and scaled
  output logic        o_undefined
);

  logic [10:0] w_op11;
  logic [9:0]  w_op10;
  logic [7:0]  w_op8;
  logic [5:0]  w_op6;
  logic [4:0]  w_rd;   // also Rt for loads, stores and CBZ/CBNZ
  logic [4:0]  w_rn;
  logic [4:0]  w_rm;
  logic [11:0] w_imm12;
  logic [8:0]  w_imm9;
  logic [25:0] w_imm26;
  logic [18:0] w_imm19;

  assign w_op11  = i_instr[31:21];
  assign w_op10  = i_instr[31:22];
  assign w_op8   = i_instr[31:24];
  assign w_op6   = i_instr[31:26];
  assign w_rd    = i_instr[4:0];
  assign w_rn    = i_instr[9:5];
  assign w_rm    = i_instr[20:16];
  assign w_imm12 = i_instr[21:10];
  assign w_imm9  = i_instr[20:12];
  assign w_imm26 = i_instr[25:0];
  assign w_imm19 = i_instr[23:5];

  // Prefix match, checked longest-first so the most specific opcode wins
  always_comb begin
    o_cw        = '0;
    o_constant  = '0;
    o_br_kind   = BR_NONE;
    o_br_offset = '0;
    o_undefined = 1'b0;
    if (w_op11 == C_OP_ADD || w_op11 == C_OP_SUB ||
        w_op11 == C_OP_AND || w_op11 == C_OP_ORR) begin
      o_cw[C_CW_DA_LSB +: 5] = w_rd;
      o_cw[C_CW_SA_LSB +: 5] = w_rn;
      o_cw[C_CW_SB_LSB +: 5] = w_rm;
      o_cw[C_CW_RW]          = 1'b1;
      case (w_op11)
        C_OP_SUB: begin
          o_cw[C_CW_FS_LSB +: 5] = C_FS_SUB;
          o_cw[C_CW_C0]          = 1'b1;
        end
        C_OP_AND: o_cw[C_CW_FS_LSB +: 5] = C_FS_AND;
        C_OP_ORR: o_cw[C_CW_FS_LSB +: 5] = C_FS_OR;
        default:  o_cw[C_CW_FS_LSB +: 5] = C_FS_ADD;
      endcase
    end else if (w_op11 == C_OP_LDUR || w_op11 == C_OP_STUR) begin
      // Address = Rn + sext(imm9); the ALU result drives the memory address
      o_cw[C_CW_SA_LSB +: 5]   = w_rn;
      o_cw[C_CW_BSEL]          = 1'b1;
      o_cw[C_CW_FS_LSB +: 5]   = C_FS_ADD;
      o_cw[C_CW_CS]            = 1'b1;
      o_cw[C_CW_SIZE_LSB +: 2] = C_SIZE_DWORD;
      o_cw[C_CW_ADDR_SEL]      = 1'b1;
      o_constant               = {{55{w_imm9[8]}}, w_imm9};
      if (w_op11 == C_OP_LDUR) begin
        o_cw[C_CW_RE]          = 1'b1;
        o_cw[C_CW_DA_LSB +: 5] = w_rd;
        o_cw[C_CW_RW]          = 1'b1;
      end else begin
        o_cw[C_CW_SB_LSB +: 5] = w_rd;
        o_cw[C_CW_WE]          = 1'b1;
        o_cw[C_CW_MW]          = 1'b1;
      end
    end else if (w_op10 == C_OP_ADDI || w_op10 == C_OP_SUBI) begin
      o_cw[C_CW_DA_LSB +: 5] = w_rd;
      o_cw[C_CW_SA_LSB +: 5] = w_rn;
      o_cw[C_CW_BSEL]        = 1'b1;
      o_cw[C_CW_RW]          = 1'b1;
      o_constant             = {52'd0, w_imm12};
      if (w_op10 == C_OP_SUBI) begin
        o_cw[C_CW_FS_LSB +: 5] = C_FS_SUB;
        o_cw[C_CW_C0]          = 1'b1;
      end else begin
        o_cw[C_CW_FS_LSB +: 5] = C_FS_ADD;
      end
    end else if (w_op8 == C_OP_CBZ || w_op8 == C_OP_CBNZ) begin
      // Rt + 0 through the ALU so the datapath's Z flag reflects Rt == 0
      o_cw[C_CW_SA_LSB +: 5] = w_rd;
      o_cw[C_CW_BSEL]        = 1'b1;
      o_cw[C_CW_FS_LSB +: 5] = C_FS_ADD;
      o_br_kind              = (w_op8 == C_OP_CBZ) ? BR_CBZ : BR_CBNZ;
      o_br_offset            = {{11{w_imm19[18]}}, w_imm19, 2'b00};
    end else if (w_op6 == C_OP_B) begin
      o_br_kind   = BR_B;
      o_br_offset = {{4{w_imm26[25]}}, w_imm26, 2'b00};
    end else begin
      o_undefined = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/control_unit_legv8.sv
`default_nettype none
// ============================================================================
// Module      : control_unit_legv8
// Description : Multi-cycle LEGv8 sequencer (FETCH/DECODE/EXECUTE) driving
//               the datapath control word, constant and PC, with branch and
//               CBZ/CBNZ resolution from the ALU status.
// Revision    : 1.0 - initial release
// ============================================================================
module control_unit_legv8
  import legv8_pkg::*;
#(
  parameter int                    PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]   PC_RESET = '0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [31:0]         instruction,
  input  logic [3:0]          status,       // {V,C,N,Z}
  output logic [31:0]         ControlWord,
  output logic [63:0]         constant,
  output logic [PC_WIDTH-1:0] pc,
  output logic                pc_oe,
  output logic                halted
);

  localparam logic [PC_WIDTH-1:0] C_PC_STEP = PC_WIDTH'(4);

  state_t              r_state;
  state_t              w_next_state;
  logic [31:0]         r_ir;
  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] r_instr_pc;

  logic [31:0]         w_dec_cw;
  logic [63:0]         w_dec_constant;
  logic [1:0]          w_br_kind;
  logic [31:0]         w_br_offset;
  logic                w_undefined;
  logic                w_taken;
  logic [PC_WIDTH-1:0] w_branch_target;
  logic                w_status_unused;

  // Only Z takes part in branch resolution
  assign w_status_unused = ^status[3:1];

  // Decode always works from the registered instruction, never the bus
  legv8_decoder u_decoder (
    .i_instr     (r_ir),
    .o_cw        (w_dec_cw),
    .o_constant  (w_dec_constant),
    .o_br_kind   (w_br_kind),
    .o_br_offset (w_br_offset),
    .o_undefined (w_undefined)
  );

  // Targets are relative to the fetch address, wrapping mod 2^PC_WIDTH
  assign w_branch_target = r_instr_pc + PC_WIDTH'($signed(w_br_offset));
  assign pc              = r_pc;

  // Branch decision from the kind and the Z flag
  always_comb begin
    w_taken = 1'b0;
    case (w_br_kind)
      BR_B:    w_taken = 1'b1;
      BR_CBZ:  w_taken = status[0];
      BR_CBNZ: w_taken = ~status[0];
      default: w_taken = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= RESET_S;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Instruction capture, PC increment and branch redirect
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pc       <= PC_RESET;
      r_instr_pc <= '0;
      r_ir       <= '0;
    end else begin
      case (r_state)
        FETCH: begin
          r_ir       <= instruction;
          r_instr_pc <= r_pc;
        end
        DECODE:  r_pc <= r_pc + C_PC_STEP;
        EXECUTE: if (w_taken) r_pc <= w_branch_target;
        default: ;
      endcase
    end
  end

  // Next-state and output decode from registered state only
  always_comb begin
    w_next_state = r_state;
    ControlWord  = '0;
    constant     = '0;
    pc_oe        = 1'b0;
    halted       = 1'b0;
    case (r_state)
      RESET_S: w_next_state = FETCH;
      FETCH: begin
        ControlWord[C_CW_CS]            = 1'b1;
        ControlWord[C_CW_RE]            = 1'b1;
        ControlWord[C_CW_IL]            = 1'b1;
        ControlWord[C_CW_SIZE_LSB +: 2] = C_SIZE_WORD;
        pc_oe                           = 1'b1;
        w_next_state                    = DECODE;
      end
      DECODE:  w_next_state = w_undefined ? HALT : EXECUTE;
      EXECUTE: begin
        ControlWord  = w_dec_cw;
        constant     = w_dec_constant;
        w_next_state = FETCH;
      end
      HALT:    halted = 1'b1;
      default: w_next_state = RESET_S;
    endcase
  end

endmodule
`default_nettype wire
